seven_segment_counter: RTL and testbench
========================================

# seven_segment_counter

Free-running four-digit decimal counter driving a multiplexed, common-anode style four-digit seven-segment display. A prescaler derives a 1 ms count tick and a 250 µs digit-scan tick from the 32 MHz board clock. A BCD counter runs 0000 to 9999. One digit at a time is enabled, with its segment pattern presented on a shared active-low segment bus. This is the top-level display block of the counter design.

## Interface
- `CLK_HZ`, 32_000_000: input clock frequency; documentation only.
- `COUNT_DIV`, 32000: clock cycles per count increment (1 ms).
- `SCAN_DIV`, 8000: clock cycles each digit stays enabled (250 µs; full refresh 1 ms).
- `clk` in 1: single clock, 32 MHz.
- `reset_` in 1: reset, asynchronous and active-low.
- `segment_` out 7: segment drive, active-low, bit order {g,f,e,d,c,b,a}.
- `digit_enable_` out 4: digit select, active-low, one-cold; bit 0 is the leftmost (thousands) digit and bit 3 is the rightmost (units) digit.

## Operation
- BCD state is four 4-bit digits: thousands, hundreds, tens, units. Reset value is 0000.
- On each count tick, units increments.
  - A digit at 9 wraps to 0 and carries into the next digit.
  - 9999 wraps to 0000.
- Scan pointer: 2-bit value, reset to 0, advanced on each scan tick as 0→1→2→3→0.
  - `digit_enable_` = ~(1 << ptr), giving 1110, 1101, 1011, 0111.
- `segment_` always shows the decode of the digit selected by ptr.
  - ptr 0 selects thousands; ptr 3 selects units.
- Decode, shown as active-high {g..a} before inversion:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - Codes 10–15 decode to 1000000 (g only, error marker).
- No leading-zero blanking: 0007 displays as "0","0","0","7".
- While `reset_` is low: `digit_enable_` = 4'b1111 (all off) and `segment_` = 7'b1111111 (all off).
- Reset asserted mid-count returns everything to the reset state immediately. Counting restarts from 0000 with both prescalers cleared.

## Timing
- All state is registered on the rising edge of `clk` and cleared asynchronously by `reset_`.
- `segment_` and `digit_enable_` are both registered and change on the same edge, so no cycle ever pairs a new enable with stale segments.
- First rising edge after reset release:
  - `digit_enable_` = 1110.
  - `segment_` = ~0111111 = 7'b1000000 ("0").
- Count prescaler counts 0..COUNT_DIV-1. Its terminal cycle produces a one-cycle tick, so the first increment to 0001 happens COUNT_DIV cycles after reset release.
- Scan prescaler counts 0..SCAN_DIV-1 independently. Each digit is enabled for exactly SCAN_DIV cycles.
- A count increment and a scan advance on the same cycle are both applied. The next cycle displays the new value on the new digit.
- Nominal rates: 1000 counts/s; 9999→0000 rollover after 10 s.

## Structure
- Shared package `seven_segment_pkg` holds:
  - the ten digit segment constants plus the error-marker constant;
  - default `COUNT_DIV` and `SCAN_DIV`;
  - a 4-bit BCD digit typedef.
- One sub-module, `bcd_to_segments`: combinational 4-bit BCD in, 7-bit active-low segments out.
- Prescalers, BCD counter and scan mux stay in the top module.

## Test plan
- Reset held 100 ns, then released. Required:
  - during reset, enables 1111 and segments 1111111;
  - after release, display reads [0][0][0][0] and enables cycle 1110→1101→1011→0111 every 250 µs.
- Run 400 ms with defaults. Display steps 0000, 0001, … once per 1 ms and reads 0399 or 0400 at end.
- Small dividers (COUNT_DIV=4, SCAN_DIV=1):
  - 0009→0010 and 0099→0100 carries are correct;
  - 9999→0000 wraps;
  - no undecoded ("?") pattern is ever shown.
- Check the enables are one-cold on every cycle after reset. Segments must match the decode of the selected digit on the same cycle.
- Assert `reset_` mid-count at value 0537. Outputs must blank immediately, and the display must restart at 0000 with first increment exactly COUNT_DIV cycles after release.
- Unit-test `bcd_to_segments` on inputs 0–15. Required: the ten digit patterns above, and ~1000000 for inputs 10–15.

Source files
------------

// File: rtl/seven_segment_pkg.sv
// Shared constants and types for the four-digit seven-segment counter.
package seven_segment_pkg;

    localparam int unsigned SEG_W         = 7;
    localparam int unsigned DIGITS        = 4;
    localparam int unsigned CLK_HZ_DEF    = 32_000_000;
    localparam int unsigned COUNT_DIV_DEF = 32_000;
    localparam int unsigned SCAN_DIV_DEF  = 8_000;

    typedef logic [3:0] bcd_digit_t;

    // Active-high {g,f,e,d,c,b,a}; the display bus is the inverse.
    localparam logic [SEG_W-1:0] SEG_0   = 7'b0111111;
    localparam logic [SEG_W-1:0] SEG_1   = 7'b0000110;
    localparam logic [SEG_W-1:0] SEG_2   = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_3   = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_4   = 7'b1100110;
    localparam logic [SEG_W-1:0] SEG_5   = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_6   = 7'b1111101;
    localparam logic [SEG_W-1:0] SEG_7   = 7'b0000111;
    localparam logic [SEG_W-1:0] SEG_8   = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9   = 7'b1101111;
    localparam logic [SEG_W-1:0] SEG_ERR = 7'b1000000;

endpackage

// File: rtl/bcd_to_segments.sv
// Combinational BCD digit to active-low seven-segment pattern; 10-15 show the g-only marker.
module bcd_to_segments
    import seven_segment_pkg::*;
(
    input  bcd_digit_t       bcd_i,
    output logic [SEG_W-1:0] segment_c
);

    logic [SEG_W-1:0] pattern_c;

    always_comb begin
        pattern_c = SEG_ERR;
        case (bcd_i)
            4'd0:    pattern_c = SEG_0;
            4'd1:    pattern_c = SEG_1;
            4'd2:    pattern_c = SEG_2;
            4'd3:    pattern_c = SEG_3;
            4'd4:    pattern_c = SEG_4;
            4'd5:    pattern_c = SEG_5;
            4'd6:    pattern_c = SEG_6;
            4'd7:    pattern_c = SEG_7;
            4'd8:    pattern_c = SEG_8;
            4'd9:    pattern_c = SEG_9;
            default: pattern_c = SEG_ERR;
        endcase
    end

    assign segment_c = ~pattern_c;

endmodule

// File: rtl/seven_segment_counter.sv
// Free-running 0000-9999 BCD counter shown on a multiplexed four-digit display.
module seven_segment_counter
    import seven_segment_pkg::*;
#(
    parameter int unsigned CLK_HZ    = CLK_HZ_DEF,
    parameter int unsigned COUNT_DIV = COUNT_DIV_DEF,
    parameter int unsigned SCAN_DIV  = SCAN_DIV_DEF
) (
    input  logic             clk,
    input  logic             reset_,
    output logic [SEG_W-1:0] segment_,
    output logic [DIGITS-1:0] digit_enable_
);

    localparam int unsigned CNT_W = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam int unsigned SCN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    if (COUNT_DIV == 0 || SCAN_DIV == 0 || CLK_HZ < COUNT_DIV) begin : g_bad_cfg
        $error("seven_segment_counter: invalid divider configuration");
    end

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [SCN_W-1:0]        scn_q, scn_d;
    logic [1:0]              ptr_q, ptr_d;
    bcd_digit_t [DIGITS-1:0] digits_q, digits_d;
    logic [SEG_W-1:0]        seg_q;
    logic [DIGITS-1:0]       en_q;
    logic                    count_tick_c;
    logic                    scan_tick_c;
    logic                    carry_c;
    bcd_digit_t              sel_digit_c;
    logic [SEG_W-1:0]        sel_seg_c;

    // Prescalers and the ripple BCD increment; index 0 is thousands, 3 is units.
    always_comb begin
        count_tick_c = (cnt_q == CNT_W'(COUNT_DIV - 1));
        scan_tick_c  = (scn_q == SCN_W'(SCAN_DIV - 1));
        cnt_d        = count_tick_c ? '0 : cnt_q + CNT_W'(1);
        scn_d        = scan_tick_c  ? '0 : scn_q + SCN_W'(1);
        ptr_d        = scan_tick_c  ? ptr_q + 2'd1 : ptr_q;
        digits_d     = digits_q;
        carry_c      = count_tick_c;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            if (carry_c) begin
                if (digits_q[i] == 4'd9) begin
                    digits_d[i] = 4'd0;
                end else begin
                    digits_d[i] = digits_q[i] + 4'd1;
                    carry_c     = 1'b0;
                end
            end
        end
        sel_digit_c = digits_q[ptr_q];
    end

    bcd_to_segments u_decode (
        .bcd_i     (sel_digit_c),
        .segment_c (sel_seg_c)
    );

    // Enable and segments load together from the same pointer so they never disagree.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            cnt_q    <= '0;
            scn_q    <= '0;
            ptr_q    <= 2'd0;
            digits_q <= '0;
            seg_q    <= '1;
            en_q     <= '1;
        end else begin
            cnt_q    <= cnt_d;
            scn_q    <= scn_d;
            ptr_q    <= ptr_d;
            digits_q <= digits_d;
            seg_q    <= sel_seg_c;
            en_q     <= ~(DIGITS'(1) << ptr_q);
        end
    end

    assign segment_      = seg_q;
    assign digit_enable_ = en_q;

endmodule

// File: tb/tb_seven_segment_counter.sv
// Self-checking bench: two divider configurations compared every cycle against an arithmetic display model.
module tb_seven_segment_counter;

    localparam int unsigned CDIV_A = 4;
    localparam int unsigned SDIV_A = 1;
    localparam int unsigned CDIV_B = 5;
    localparam int unsigned SDIV_B = 3;

    logic       clk;
    logic       reset_;
    logic [6:0] seg_a, seg_b, dec_out;
    logic [3:0] en_a, en_b, dec_in;

    int errors;
    int checks;
    int unsigned n;

    seven_segment_counter #(.COUNT_DIV(CDIV_A), .SCAN_DIV(SDIV_A)) dut_a (
        .clk(clk), .reset_(reset_), .segment_(seg_a), .digit_enable_(en_a)
    );

    seven_segment_counter #(.COUNT_DIV(CDIV_B), .SCAN_DIV(SDIV_B)) dut_b (
        .clk(clk), .reset_(reset_), .segment_(seg_b), .digit_enable_(en_b)
    );

    bcd_to_segments u_dec (.bcd_i(dec_in), .segment_c(dec_out));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Active-high {g..a} glyph for a decimal digit.
    function automatic logic [6:0] ref_pat(input int unsigned d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1101111;
            default: return 7'b1000000;
        endcase
    endfunction

    // Display after the n-th edge since release reflects state after n-1 edges.
    function automatic logic [10:0] exp_out(input int unsigned cyc, input int unsigned cdiv,
                                            input int unsigned sdiv);
        int unsigned val, ptr, dig;
        logic [3:0]  one;
        one = 4'b0001;
        val = ((cyc - 1) / cdiv) % 10000;
        ptr = ((cyc - 1) / sdiv) % 4;
        case (ptr)
            0:       dig = val / 1000;
            1:       dig = (val / 100) % 10;
            2:       dig = (val / 10) % 10;
            default: dig = val % 10;
        endcase
        return {~(one << ptr), ~ref_pat(dig)};
    endfunction

    task automatic release_reset();
        @(negedge clk);
        reset_ = 1'b1;
        n = 0;
    endtask

    task automatic test_decoder();
        int unsigned v;
        for (int i = 0; i < 32; i++) begin
            v = (i < 16) ? i : $urandom_range(0, 15);
            dec_in = 4'(v);
            #1;
            checks++;
            if (dec_out !== ~ref_pat(v)) begin
                errors++;
                $display("FAIL decoder in=%0d got=%b want=%b", v, dec_out, ~ref_pat(v));
            end
        end
    endtask

    task automatic test_reset();
        reset_ = 1'b0;
        #100;
        @(posedge clk);
        #1;
        checks++;
        if (seg_a !== 7'b1111111 || en_a !== 4'b1111 || seg_b !== 7'b1111111 || en_b !== 4'b1111) begin
            errors++;
            $display("FAIL reset_blank a=%b/%b b=%b/%b want 1111111/1111", seg_a, en_a, seg_b, en_b);
        end
        release_reset();
        @(posedge clk);
        #1;
        n++;
        checks++;
        if (en_a !== 4'b1110 || seg_a !== 7'b1000000 || en_b !== 4'b1110 || seg_b !== 7'b1000000) begin
            errors++;
            $display("FAIL first_edge a=%b/%b b=%b/%b want 1000000/1110", seg_a, en_a, seg_b, en_b);
        end
    endtask

    // Runs until the n-th edge, checking both DUTs every cycle.
    task automatic test_counting(input int unsigned upto, input string tag);
        logic [10:0] ea, eb;
        while (n < upto) begin
            @(posedge clk);
            #1;
            n++;
            ea = exp_out(n, CDIV_A, SDIV_A);
            eb = exp_out(n, CDIV_B, SDIV_B);
            checks++;
            if ({en_a, seg_a} !== ea) begin
                errors++;
                $display("FAIL %s_a n=%0d got en=%b seg=%b want en=%b seg=%b",
                         tag, n, en_a, seg_a, ea[10:7], ea[6:0]);
            end
            checks++;
            if ({en_b, seg_b} !== eb) begin
                errors++;
                $display("FAIL %s_b n=%0d got en=%b seg=%b want en=%b seg=%b",
                         tag, n, en_b, seg_b, eb[10:7], eb[6:0]);
            end
            checks++;
            if (!$onehot(~en_a) || !$onehot(~en_b) || seg_a === 7'b0111111 || seg_b === 7'b0111111) begin
                errors++;
                $display("FAIL %s_sanity n=%0d got en_a=%b en_b=%b seg_a=%b seg_b=%b want one-cold, decoded",
                         tag, n, en_a, en_b, seg_a, seg_b);
            end
        end
    endtask

    // Reset asynchronously between edges; outputs must blank without waiting for a clock.
    task automatic test_mid_reset(input int unsigned hold, input int unsigned offset, input string tag);
        #(offset);
        reset_ = 1'b0;
        #1;
        checks++;
        if (seg_a !== 7'b1111111 || en_a !== 4'b1111 || seg_b !== 7'b1111111 || en_b !== 4'b1111) begin
            errors++;
            $display("FAIL %s_blank n=%0d a=%b/%b b=%b/%b want 1111111/1111", tag, n, seg_a, en_a, seg_b, en_b);
        end
        repeat (hold) @(posedge clk);
        #1;
        checks++;
        if (seg_a !== 7'b1111111 || en_a !== 4'b1111 || seg_b !== 7'b1111111 || en_b !== 4'b1111) begin
            errors++;
            $display("FAIL %s_hold a=%b/%b b=%b/%b want 1111111/1111", tag, seg_a, en_a, seg_b, en_b);
        end
        release_reset();
    endtask

    task automatic test_random_resets();
        for (int k = 0; k < 4; k++) begin
            test_counting(n + $urandom_range(20, 400), "rand_run");
            test_mid_reset($urandom_range(1, 3), $urandom_range(1, 7), "rand_reset");
        end
        test_counting(60, "rand_tail");
    endtask

    initial begin
        errors = 0;
        checks = 0;
        n      = 0;
        reset_ = 1'b0;
        dec_in = 4'd0;
        test_decoder();
        test_reset();
        test_counting(1604, "count_to_0400");
        // dut_a reads 0537 from edge 2149 on; reset mid-way through that count.
        test_counting(537 * CDIV_A + 2, "count_to_0537");
        test_mid_reset(2, 2, "reset_at_0537");
        test_counting(200, "restart");
        test_counting(40020, "wrap_9999");
        test_random_resets();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
